pa_regfile_sb: RTL

PA_REGFILE_SB -- requirements
Module: pa_regfile_sb

---
 rtl/pa_pkg.sv | 12 +
 rtl/pa_scoreboard.sv | 51 +++++
 rtl/pa_regfile_sb.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pa_pkg.sv
// Shared sizing and INIT/RUN state encoding for the register file with
// scoreboard.
package pa_pkg;
    localparam int PA_NREG = 32;
    localparam int PA_DW   = 32;
    localparam int PA_IW   = 5;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pa_state_e;
endpackage

// File: rtl/pa_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, with a
// same-cycle writeback bypass folded into the hazard check.
module pa_scoreboard
    import pa_pkg::*;
#(
    parameter int NREG = PA_NREG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [PA_IW-1:0] set_idx,
    input  logic             clr_en,
    input  logic [PA_IW-1:0] clr_idx,
    input  logic [PA_IW-1:0] rs,
    input  logic [PA_IW-1:0] rt,
    input  logic [PA_IW-1:0] rd,
    input  logic             wen,
    output logic [NREG-1:0]  busy,
    output logic             hazard,
    output logic             stray_clr
);
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_eff;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
            logic set_hit;
            logic clr_hit;

            assign clr_hit = clr_en & (clr_idx == PA_IW'(gi));
            // Register 0 is hard-wired zero, so it can never become busy.
            assign set_hit = set_en & (set_idx == PA_IW'(gi)) & (gi != 0);
            assign busy_eff[gi] = busy_reg[gi] & ~clr_hit;

            // A set takes priority over a clear of the same index.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    busy_reg[gi] <= 1'b0;
                end else if (set_hit) begin
                    busy_reg[gi] <= 1'b1;
                end else if (clr_hit) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign busy      = busy_reg;
    assign hazard    = busy_eff[rs] | busy_eff[rt] | (wen & busy_eff[rd]);
    assign stray_clr = clr_en & (clr_idx != '0) & ~busy_reg[clr_idx];
endmodule

// File: rtl/pa_regfile_sb.sv
// Architectural register file with issue-side hazard interlock, a one-cycle
// operand read path with writeback bypass, and a zeroing INIT sweep.
module pa_regfile_sb
    import pa_pkg::*;
#(
    parameter int NREG = PA_NREG,
    parameter int DW   = PA_DW,
    parameter int SCW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [PA_IW-1:0] iss_rs,
    input  logic [PA_IW-1:0] iss_rt,
    input  logic [PA_IW-1:0] iss_rd,
    input  logic             iss_wen,
    output logic             rd_valid,
    output logic [DW-1:0]    rd_a,
    output logic [DW-1:0]    rd_b,
    output logic [PA_IW-1:0] rd_dest,
    input  logic             wb_valid,
    input  logic [PA_IW-1:0] wb_rd,
    input  logic [DW-1:0]    wb_data,
    output logic [NREG-1:0]  busy,
    output logic [SCW-1:0]   stall_cnt,
    output logic             wb_err
);
    pa_state_e        state_reg, state_next;
    logic [PA_IW-1:0] clr_idx_reg, clr_idx_next;
    logic [DW-1:0]    regs [NREG];
    logic             run;
    logic             wb_en;
    logic             accept;
    logic             hazard;
    logic             stray_wb;
    logic [DW-1:0]    op_a;
    logic [DW-1:0]    op_b;

    assign run       = (state_reg == ST_RUN);
    assign wb_en     = run & wb_valid;
    // Gating with rst_n keeps the reset cycle itself from accepting anything.
    assign iss_ready = rst_n & run & ~hazard;
    assign accept    = iss_valid & iss_ready;

    pa_scoreboard #(.NREG(NREG)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (accept & iss_wen),
        .set_idx   (iss_rd),
        .clr_en    (wb_en),
        .clr_idx   (wb_rd),
        .rs        (iss_rs),
        .rt        (iss_rt),
        .rd        (iss_rd),
        .wen       (iss_wen),
        .busy      (busy),
        .hazard    (hazard),
        .stray_clr (stray_wb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_INIT;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        if (state_reg == ST_INIT) begin
            clr_idx_next = clr_idx_reg + 1'b1;
            if (clr_idx_reg == PA_IW'(NREG - 1)) begin
                state_next   = ST_RUN;
                clr_idx_next = '0;
            end
        end
    end

    // Single write port shared by the INIT sweep and RUN-time writebacks.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!run) begin
                regs[clr_idx_reg] <= '0;
            end else if (wb_valid && (wb_rd != '0)) begin
                regs[wb_rd] <= wb_data;
            end
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        if (iss_rs != '0) begin
            op_a = (wb_en && (wb_rd == iss_rs)) ? wb_data : regs[iss_rs];
        end
        if (iss_rt != '0) begin
            op_b = (wb_en && (wb_rd == iss_rt)) ? wb_data : regs[iss_rt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_a      <= '0;
            rd_b      <= '0;
            rd_dest   <= '0;
            stall_cnt <= '0;
            wb_err    <= 1'b0;
        end else begin
            rd_valid <= accept;
            if (accept) begin
                rd_a    <= op_a;
                rd_b    <= op_b;
                rd_dest <= iss_rd;
            end
            if (run && iss_valid && !iss_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (stray_wb) begin
                wb_err <= 1'b1;
            end
        end
    end
endmodule
